// File: rtl/hdc_pkg.sv
// rtl/hdc_pkg.sv - shared constants and FSM encoding for the class hypervector binarizer
// Purpose: single home for the hypervector geometry, the binarization threshold and
//          the read-out FSM state encoding. No ports.
package hdc_pkg;

  localparam int CHUNK_W     = 5;
  localparam int CNT_W       = 8;
  localparam int NUM_CHUNKS  = 10;
  localparam int NUM_CLASSES = 4;
  localparam int ADDR_W      = 6;
  localparam int THRESHOLD   = 30;

  localparam int CLS_W = $clog2(NUM_CLASSES);
  localparam int IDX_W = $clog2(NUM_CHUNKS);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_SEND,
    ST_DONE
  } state_t;

endpackage

// File: rtl/chunk_thresholder.sv
// rtl/chunk_thresholder.sv - maps a chunk of stored counters to binary hypervector bits
// Purpose: combinational; bit i = (counter lane i >= THRESH), unsigned and inclusive.
//          Inverse companion of the training accumulator adder.
// Ports:
//   counters  in   LANES*LANE_W  packed counters, lane 0 in the low bits
//   bits      out  LANES         thresholded bits, bit i from lane i
module chunk_thresholder
  import hdc_pkg::*;
#(
  parameter int LANES  = CHUNK_W,
  parameter int LANE_W = CNT_W,
  parameter int THRESH = THRESHOLD
) (
  input  logic [LANES*LANE_W-1:0] counters,
  output logic [LANES-1:0]        bits
);

  always_comb begin
    bits = '0;
    for (int i = 0; i < LANES; i++) begin
      bits[i] = (counters[i*LANE_W +: LANE_W] >= LANE_W'(THRESH));
    end
  end

endmodule

// File: rtl/class_hv_binarizer.sv
// rtl/class_hv_binarizer.sv - reads one class's counter chunks and streams them binarized
// Purpose: on start, walks the NUM_CHUNKS counter chunks of class_sel in the class
//          memory, thresholds each chunk and presents it on a valid/ready stream.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   start      pulse, accepted only while idle; class_sel sampled with it
//   class_sel  class to binarize
//   busy       high from the accepted start through the done cycle
//   rd_en      one-cycle memory read strobe
//   rd_addr    class_sel*NUM_CHUNKS + chunk index
//   rd_data    counter chunk, valid one cycle after rd_en
//   out_valid  out_chunk/out_last valid
//   out_ready  downstream accept
//   out_chunk  thresholded chunk
//   out_last   marks the final chunk of the hypervector
//   done       one-cycle pulse after the last chunk handshake
module class_hv_binarizer
  import hdc_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [CLS_W-1:0]         class_sel,
  output logic                     busy,
  output logic                     rd_en,
  output logic [ADDR_W-1:0]        rd_addr,
  input  logic [CHUNK_W*CNT_W-1:0] rd_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CHUNK_W-1:0]       out_chunk,
  output logic                     out_last,
  output logic                     done
);

  state_t             state_q, state_d;
  logic [CLS_W-1:0]   cls_q;
  logic [IDX_W-1:0]   idx_q;
  logic [CHUNK_W-1:0] chunk_q;
  logic               last_q;
  logic [CHUNK_W-1:0] thr_bits;
  logic               is_last_idx;

  assign is_last_idx = (idx_q == IDX_W'(NUM_CHUNKS - 1));

  chunk_thresholder u_thr (
    .counters (rd_data),
    .bits     (thr_bits)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_REQ;
      ST_REQ:  state_d = ST_WAIT;
      ST_WAIT: state_d = ST_SEND;
      ST_SEND: if (out_ready) state_d = is_last_idx ? ST_DONE : ST_REQ;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cls_q   <= '0;
      idx_q   <= '0;
      chunk_q <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      // class_sel is only latched from idle, so a start during a run cannot
      // redirect the remaining reads.
      if (state_q == ST_IDLE && start) begin
        cls_q <= class_sel;
        idx_q <= '0;
      end
      // rd_data is meaningful only in the cycle after the read strobe.
      if (state_q == ST_WAIT) begin
        chunk_q <= thr_bits;
        last_q  <= is_last_idx;
      end
      if (state_q == ST_SEND && out_ready && !is_last_idx) begin
        idx_q <= idx_q + 1'b1;
      end
    end
  end

  assign rd_addr   = ADDR_W'(cls_q) * ADDR_W'(NUM_CHUNKS) + ADDR_W'(idx_q);
  assign rd_en     = (state_q == ST_REQ);
  assign out_valid = (state_q == ST_SEND);
  assign out_chunk = chunk_q;
  assign out_last  = (state_q == ST_SEND) && last_q;
  assign done      = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);

endmodule
